// File: rtl/cgra_config_loader.sv
// -----------------------------------------------------------------------------
// cgra_config_loader
//
// Purpose:
//   Turns a packetised stream of 64-bit config words into write transactions
//   for the per-PE configuration RAMs of the CGRA array. A packet is one header
//   word followed by len_m1+1 payload words. Payload beats are written to
//   consecutive slots (wrapping mod DEPTH) of one PE, or of every PE on
//   broadcast. Malformed packets are flagged, counted and drained so the
//   stream never locks up.
//
// Header word layout:
//   [7:0]   pe_id   (8'hFF = broadcast)
//   [11:8]  start slot (low ADDR_WIDTH bits used)
//   [19:16] len_m1  (payload count - 1)
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en             loader enable; s_ready follows it combinationally
//   s_valid/s_ready/s_data/s_last   input stream (beat taken on valid&&ready)
//   cfg_wr_en      registered write strobe, one-hot per PE or all-ones
//   cfg_wr_addr    registered slot address shared by all PEs
//   cfg_wr_data    registered config frame shared by all PEs
//   busy           high while in PAYLOAD or DRAIN
//   pkt_done       one-cycle pulse with the final write of a good packet
//   err_sticky     set on any protocol error, cleared only by reset
//   err_count      saturating count of erroneous packets
// -----------------------------------------------------------------------------
module cgra_config_loader #(
    parameter int NUM_PE     = 16,
    parameter int PE_ID_W    = $clog2(NUM_PE),
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic [NUM_PE-1:0]     cfg_wr_en,
    output logic [ADDR_WIDTH-1:0] cfg_wr_addr,
    output logic [DATA_WIDTH-1:0] cfg_wr_data,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  err_sticky,
    output logic [7:0]            err_count
);

    localparam int          LEN_W     = 4;
    localparam logic [7:0]  PE_BCAST  = 8'hFF;
    localparam logic [7:0]  NUM_PE_B  = 8'(NUM_PE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic                  bcast_q, bcast_d;
    logic                  bad_q, bad_d;
    logic [PE_ID_W-1:0]    target_q, target_d;
    logic [ADDR_WIDTH-1:0] slot_q, slot_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic [NUM_PE-1:0]     wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  pkt_done_q, pkt_done_d;
    logic                  err_sticky_q, err_sticky_d;
    logic [7:0]            err_count_q, err_count_d;

    logic                  beat;
    logic                  err_event;
    logic [7:0]            hdr_pe;
    logic                  hdr_pe_ok;
    logic [NUM_PE-1:0]     target_mask;

    assign s_ready   = en;
    assign beat      = s_valid && en;
    assign hdr_pe    = s_data[7:0];
    assign hdr_pe_ok = (hdr_pe < NUM_PE_B) || (hdr_pe == PE_BCAST);

    // Strobe pattern for the latched target of the packet in flight.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        target_mask = '0;
        if (bcast_q) begin
            target_mask = '1;
        end else begin
            target_mask[target_q] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        bcast_d      = bcast_q;
        bad_d        = bad_q;
        target_d     = target_q;
        slot_d       = slot_q;
        remaining_d  = remaining_q;
        wr_en_d      = '0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        pkt_done_d   = 1'b0;
        err_event    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    if (s_last) begin
                        // Header with no payload behind it.
                        err_event = 1'b1;
                    end else begin
                        bcast_d     = (hdr_pe == PE_BCAST);
                        bad_d       = !hdr_pe_ok;
                        target_d    = hdr_pe[PE_ID_W-1:0];
                        slot_d      = s_data[8 +: ADDR_WIDTH];
                        remaining_d = s_data[19:16];
                        state_d     = ST_PAYLOAD;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (beat) begin
                    // A bad target still consumes its payload, just silently.
                    if (!bad_q) begin
                        wr_en_d   = target_mask;
                        wr_addr_d = slot_q;
                        wr_data_d = s_data;
                    end
                    slot_d = slot_q + 1'b1;  // wraps mod DEPTH

                    if (remaining_q == '0) begin
                        if (s_last) begin
                            state_d = ST_IDLE;
                            if (bad_q) begin
                                err_event = 1'b1;
                            end else begin
                                pkt_done_d = 1'b1;
                            end
                        end else begin
                            // Overlong: swallow the excess beats.
                            err_event = 1'b1;
                            state_d   = ST_DRAIN;
                        end
                    end else if (s_last) begin
                        // Truncated: writes already issued stay issued.
                        err_event = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                if (beat && s_last) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Each transition above raises err_event at most once per packet.
        err_sticky_d = err_sticky_q | err_event;
        err_count_d  = err_count_q;
        if (err_event && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bcast_q      <= 1'b0;
            bad_q        <= 1'b0;
            target_q     <= '0;
            slot_q       <= '0;
            remaining_q  <= '0;
            wr_en_q      <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            pkt_done_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q      <= state_d;
            bcast_q      <= bcast_d;
            bad_q        <= bad_d;
            target_q     <= target_d;
            slot_q       <= slot_d;
            remaining_q  <= remaining_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            pkt_done_q   <= pkt_done_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign cfg_wr_en   = wr_en_q;
    assign cfg_wr_addr = wr_addr_q;
    assign cfg_wr_data = wr_data_q;
    assign pkt_done    = pkt_done_q;
    assign err_sticky  = err_sticky_q;
    assign err_count   = err_count_q;
    assign busy        = (state_q == ST_PAYLOAD) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_cgra_config_loader.sv
// -----------------------------------------------------------------------------
// tb_cgra_config_loader
//
// Directed packets are driven into the loader; for every write they should
// cause, the expected strobe/address/data/pkt_done tuple is queued. A monitor
// pops and compares each time the DUT presents a write strobe or pkt_done.
// Error counters, busy, s_ready and reset values are checked inline.
// -----------------------------------------------------------------------------
module tb_cgra_config_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        s_last;
    logic [15:0] cfg_wr_en;
    logic [3:0]  cfg_wr_addr;
    logic [63:0] cfg_wr_data;
    logic        busy;
    logic        pkt_done;
    logic        err_sticky;
    logic [7:0]  err_count;

    int vectors   = 0;
    int miscompares = 0;
    logic toggle_en = 1'b0;

    typedef struct packed {
        logic [15:0] en;
        logic [3:0]  addr;
        logic [63:0] data;
        logic        done;
    } wr_t;

    wr_t exp_q[$];

    cgra_config_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .cfg_wr_en  (cfg_wr_en),
        .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] pe, input logic [3:0] slot,
                                        input logic [3:0] len_m1);
        logic [63:0] h;
        h        = 64'hDEAD_0000_0000_0000;  // ignored bits set to non-zero
        h[7:0]   = pe;
        h[11:8]  = slot;
        h[19:16] = len_m1;
        return h;
    endfunction

    task automatic expect_wr(input logic [15:0] wen, input logic [3:0] addr,
                             input logic [63:0] data, input logic done);
        wr_t w;
        w.en   = wen;
        w.addr = addr;
        w.data = data;
        w.done = done;
        exp_q.push_back(w);
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input logic [63:0] d, input logic last);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        forever begin
            @(posedge clk);
            if (en) break;
            #1;
            if (toggle_en) begin
                check("s_ready_follows_en", {63'd0, s_ready}, {63'd0, en});
                en = ~en;
            end
            n++;
            if (n > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: beat %h not accepted after %0d cycles, expected acceptance", d, n);
                break;
            end
        end
        #1;
        s_valid = 1'b0;
        if (toggle_en) begin
            en = ~en;
            check("s_ready_follows_en", {63'd0, s_ready}, {63'd0, en});
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        wr_t act;
        wr_t exp;
        if (rst_n && ((cfg_wr_en != '0) || pkt_done)) begin
            act.en   = cfg_wr_en;
            act.addr = cfg_wr_addr;
            act.data = cfg_wr_data;
            act.done = pkt_done;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got en=%h addr=%0d data=%h done=%b, expected no write",
                         act.en, act.addr, act.data, act.done);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    miscompares++;
                    $display("FAIL write: got en=%h addr=%0d data=%h done=%b, expected en=%h addr=%0d data=%h done=%b",
                             act.en, act.addr, act.data, act.done,
                             exp.en, exp.addr, exp.data, exp.done);
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        #1;
        check("rst_wr_en",   64'(cfg_wr_en),   64'd0);
        check("rst_wr_addr", 64'(cfg_wr_addr), 64'd0);
        check("rst_wr_data", cfg_wr_data,      64'd0);
        check("rst_busy",    64'(busy),        64'd0);
        check("rst_err",     64'(err_sticky),  64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: PE3, slot 2, three words.
        expect_wr(16'h0008, 4'd2, 64'hA, 1'b0);
        expect_wr(16'h0008, 4'd3, 64'hB, 1'b0);
        expect_wr(16'h0008, 4'd4, 64'hC, 1'b1);
        send(hdr(8'd3, 4'd2, 4'd2), 1'b0);
        check("busy_in_payload", 64'(busy), 64'd1);
        send(64'hA, 1'b0);
        send(64'hB, 1'b0);
        send(64'hC, 1'b1);
        check("t1_err_sticky", 64'(err_sticky), 64'd0);

        // 2: broadcast, slot 14 wrapping to 1.
        expect_wr(16'hFFFF, 4'd14, 64'hD0, 1'b0);
        expect_wr(16'hFFFF, 4'd15, 64'hD1, 1'b0);
        expect_wr(16'hFFFF, 4'd0,  64'hD2, 1'b0);
        expect_wr(16'hFFFF, 4'd1,  64'hD3, 1'b1);
        send(hdr(8'hFF, 4'd14, 4'd3), 1'b0);
        for (int i = 0; i < 4; i++) send(64'hD0 + 64'(i), i == 3);

        // 3: bad target, then a good packet.
        send(hdr(8'd20, 4'd0, 4'd1), 1'b0);
        send(64'h111, 1'b0);
        send(64'h222, 1'b1);
        check("t3_err_sticky", 64'(err_sticky), 64'd1);
        check("t3_err_count",  64'(err_count),  64'd1);
        check("t3_busy_idle",  64'(busy),       64'd0);
        expect_wr(16'h0020, 4'd0, 64'h5555, 1'b1);
        send(hdr(8'd5, 4'd0, 4'd0), 1'b0);
        send(64'h5555, 1'b1);

        // 4a: truncated after two of four words.
        expect_wr(16'h0002, 4'd7, 64'h71, 1'b0);
        expect_wr(16'h0002, 4'd8, 64'h72, 1'b0);
        send(hdr(8'd1, 4'd7, 4'd3), 1'b0);
        send(64'h71, 1'b0);
        send(64'h72, 1'b1);
        check("t4_trunc_count", 64'(err_count), 64'd2);

        // 4b: overlong, one written word then two drained.
        expect_wr(16'h0004, 4'd9, 64'h91, 1'b0);
        send(hdr(8'd2, 4'd9, 4'd0), 1'b0);
        send(64'h91, 1'b0);
        check("t4_over_count", 64'(err_count), 64'd3);
        check("t4_busy_drain", 64'(busy),      64'd1);
        send(64'h92, 1'b0);
        send(64'h93, 1'b1);
        expect_wr(16'h0010, 4'd3, 64'h41, 1'b0);
        expect_wr(16'h0010, 4'd4, 64'h42, 1'b1);
        send(hdr(8'd4, 4'd3, 4'd1), 1'b0);
        send(64'h41, 1'b0);
        send(64'h42, 1'b1);
        check("t4_after_count", 64'(err_count), 64'd3);

        // 4c: header with s_last and no payload.
        send(hdr(8'd2, 4'd0, 4'd0), 1'b1);
        check("hdr_only_count", 64'(err_count), 64'd4);
        check("hdr_only_busy",  64'(busy),      64'd0);

        // 5: en toggling every cycle.
        for (int i = 0; i < 4; i++) expect_wr(16'h0040, 4'(12 + i), 64'hE0 + 64'(i), i == 3);
        toggle_en = 1'b1;
        send(hdr(8'd6, 4'd12, 4'd3), 1'b0);
        for (int i = 0; i < 4; i++) send(64'hE0 + 64'(i), i == 3);
        toggle_en = 1'b0;
        en = 1'b1;

        // 6: reset after one of four words.
        expect_wr(16'h0080, 4'd5, 64'h777, 1'b0);
        send(hdr(8'd7, 4'd5, 4'd3), 1'b0);
        send(64'h777, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_wr_en",   64'(cfg_wr_en),   64'd0);
        check("t6_wr_addr", 64'(cfg_wr_addr), 64'd0);
        check("t6_wr_data", cfg_wr_data,      64'd0);
        check("t6_done",    64'(pkt_done),    64'd0);
        check("t6_busy",    64'(busy),        64'd0);
        check("t6_sticky",  64'(err_sticky),  64'd0);
        check("t6_count",   64'(err_count),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_wr(16'h0001, 4'd0, 64'h0F0F, 1'b1);
        send(hdr(8'd0, 4'd0, 4'd0), 1'b0);
        send(64'h0F0F, 1'b1);
        check("t6_after_count", 64'(err_count), 64'd0);

        repeat (4) @(negedge clk);
        check("all_writes_seen", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
